// File: rtl/keypad_decoder_if.sv
// Keypad decoder bus: button pulses and key levels in, synthesizer control state out.
interface keypad_decoder_if #(
  parameter int NUM_KEYS = 13
);
  logic                octave_pulse;
  logic                mode_pulse;
  logic [NUM_KEYS-1:0] keys;
  logic [2:0]          octave;
  logic [1:0]          mode;
  logic [3:0]          note;
  logic                note_valid;
  logic                note_change;

  modport master (
    output octave_pulse, mode_pulse, keys,
    input  octave, mode, note, note_valid, note_change
  );

  modport slave (
    input  octave_pulse, mode_pulse, keys,
    output octave, mode, note, note_valid, note_change
  );
endinterface

// File: rtl/keypad_decoder.sv
// Synth control state: wrapping octave counter, waveform mode FSM and a
// debounced, lowest-key-wins note with valid and change-pulse outputs.
module keypad_decoder #(
  parameter int NUM_KEYS      = 13,
  parameter int NUM_OCTAVES   = 5,
  parameter int STABLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  keypad_decoder_if.slave  bus
);

  localparam int              CNT_W    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]      OCT_LAST = 3'(NUM_OCTAVES - 1);

  typedef enum logic [1:0] {
    MODE_SQUARE   = 2'd0,
    MODE_SAW      = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SINE     = 2'd3
  } mode_e;

  logic [2:0]       r_octave;
  mode_e            r_mode;
  logic [3:0]       r_cand_idx;
  logic             r_cand_vld;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_note;
  logic             r_note_valid;
  logic             r_note_change;

  logic [3:0]       w_cand_idx;
  logic             w_cand_vld;
  logic             w_cand_same;
  logic             w_commit;
  logic [3:0]       w_new_note;
  logic             w_new_changed;

  // Priority encoder: scanning downward lets the lowest pressed key win a chord.
  always_comb begin
    w_cand_idx = 4'd0;
    w_cand_vld = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (bus.keys[i]) begin
        w_cand_idx = 4'(i);
        w_cand_vld = 1'b1;
      end else begin
        w_cand_idx = w_cand_idx;
        w_cand_vld = w_cand_vld;
      end
    end
  end

  // NONE is stored with index 0, so a plain compare of {vld, idx} suffices.
  always_comb begin
    w_cand_same   = ({w_cand_vld, w_cand_idx} == {r_cand_vld, r_cand_idx});
    w_commit      = w_cand_same && (r_cnt == CNT_MAX);
    w_new_note    = r_cand_vld ? r_cand_idx : r_note;
    w_new_changed = (r_cand_vld != r_note_valid) || (w_new_note != r_note);
  end

  // Octave counter, wraps after the last octave setting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_octave <= 3'd0;
    end else if (bus.octave_pulse) begin
      r_octave <= (r_octave == OCT_LAST) ? 3'd0 : r_octave + 3'd1;
    end else begin
      r_octave <= r_octave;
    end
  end

  // Waveform mode state machine, one step per mode pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mode <= MODE_SQUARE;
    end else if (bus.mode_pulse) begin
      case (r_mode)
        MODE_SQUARE:   r_mode <= MODE_SAW;
        MODE_SAW:      r_mode <= MODE_TRIANGLE;
        MODE_TRIANGLE: r_mode <= MODE_SINE;
        MODE_SINE:     r_mode <= MODE_SQUARE;
        default:       r_mode <= MODE_SQUARE;
      endcase
    end else begin
      r_mode <= r_mode;
    end
  end

  // Debounce and commit; while saturated the same value re-commits silently.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cand_idx    <= 4'd0;
      r_cand_vld    <= 1'b0;
      r_cnt         <= '0;
      r_note        <= 4'd0;
      r_note_valid  <= 1'b0;
      r_note_change <= 1'b0;
    end else if (!w_cand_same) begin
      r_cand_idx    <= w_cand_idx;
      r_cand_vld    <= w_cand_vld;
      r_cnt         <= '0;
      r_note_change <= 1'b0;
    end else if (!w_commit) begin
      r_cnt         <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      r_note_change <= 1'b0;
    end else begin
      r_note        <= w_new_note;
      r_note_valid  <= r_cand_vld;
      r_note_change <= w_new_changed;
    end
  end

  assign bus.octave      = r_octave;
  assign bus.mode        = r_mode;
  assign bus.note        = r_note;
  assign bus.note_valid  = r_note_valid;
  assign bus.note_change = r_note_change;

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
Consumer-side counterpart of the keypad front end. It takes the one-cycle octave and mode button pulses and the already-synchronized note key vector, and maintains the synthesizer's control state. That state is a wrapping octave counter, a waveform-mode state machine, and a debounced, priority-encoded note with valid and change-pulse outputs. Its outputs feed the oscillator and waveform-select logic directly.

Parameters:
NUM_KEYS, 13, number of note keys (key 0 = lowest note C, key 12 = upper C)
NUM_OCTAVES, 5, number of octave settings; octave counts 0..NUM_OCTAVES-1
STABLE_CYCLES, 8, consecutive cycles a key candidate must hold before commit (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
octave_pulse  input  1  single-cycle pulse, advance octave
mode_pulse  input  1  single-cycle pulse, advance waveform mode
keys  input  NUM_KEYS  synchronized key levels, 1 = pressed
octave  output  3  current octave index
mode  output  2  current waveform: 0 SQUARE, 1 SAW, 2 TRIANGLE, 3 SINE
note  output  4  committed key index
note_valid  output  1  committed note present
note_change  output  1  one-cycle pulse when (note_valid, note) commits a new value

Behaviour:
- Reset: clk and n_rst only; asynchronous, active-low.
  - Outputs: octave=0, mode=SQUARE(0), note=0, note_valid=0, note_change=0.
  - Internal: candidate register = NONE, stability counter = 0.
  - Reset mid-press: all state clears immediately. After release of n_rst, the held key is re-qualified from scratch.
- Octave:
  - On an edge with octave_pulse=1, octave <= octave+1. At NUM_OCTAVES-1 it wraps to 0.
  - Visible the cycle after the pulse. No pulse: octave holds.
- Mode FSM: SQUARE->SAW->TRIANGLE->SINE->SQUARE, one step per mode_pulse edge. No pulse: hold.
- Simultaneous octave_pulse and mode_pulse: both advance on the same edge, independently.
- Pulses held high for N cycles advance N times. The pulse source guarantees single-cycle pulses; the decoder does not re-edge-detect.
- Key candidate (combinational): index of the lowest-numbered set bit of keys, or NONE if keys==0. Chords resolve to the lowest key.
- Debounce, evaluated each edge:
  - candidate != cand_q: cand_q <= candidate, cnt <= 0.
  - Otherwise, if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Otherwise (cnt == STABLE_CYCLES-1, saturated): commit cand_q.
- Commit:
  - cand_q = key k: note <= k, note_valid <= 1.
  - cand_q = NONE: note_valid <= 0; note holds its last value.
  - note_change <= 1 for exactly one cycle, only when the committed (note_valid, note) differs from its previous value. Re-committing the same value every cycle while saturated produces no further pulses.
- Latency: keys stable from sampling edge E0 commit at edge E0+STABLE_CYCLES. With STABLE_CYCLES=8, note_valid and note_change rise after the 9th edge.
- Glitches: any candidate change before saturation restarts the count. Glitches shorter than STABLE_CYCLES cycles never commit.
- Key to key (k1 held, switch to k2): note_valid stays 1 throughout, note changes after the qualification interval, and note_change pulses once.
- Release (key to NONE): after qualification, note_valid falls and note_change pulses once.
- Independence: mode and octave changes never affect note state, and vice versa.
- Width rules: cnt is wide enough for STABLE_CYCLES-1. Unused note and octave codes are never produced.

Test Plan:
- Reset, then 7 octave_pulses spaced 3 cycles apart -> octave sequence 1,2,3,4,0,1,2; mode stays 0; no note_change.
- 5 mode_pulses, with octave_pulse coincident on the 3rd -> mode 1,2,3,0,1; octave=1 after the coincident edge.
- keys=0x010 held 20 cycles -> note=4, note_valid=1, note_change high exactly 1 cycle at the 9th edge; then keys=0 -> note_valid=0 after 9 edges, note stays 4, one note_change pulse.
- keys=0x001 for 5 cycles then 0, repeated 3 times -> note_valid never asserts, note_change never pulses.
- keys=0x1A0 (keys 5,7,8) held -> note=5; then key 5 drops (0x180) -> note=7 after qualification, note_valid stays 1, one note_change pulse.
- keys=0x004 committed, n_rst pulsed low for 1 cycle while key still held -> all outputs 0 immediately; note=2, note_valid=1 re-commit 9 edges after reset release.
